// File: rtl/program_sequencer.sv
// Program-flow stage: owns the program counter and a small shift-register return stack.
// Each cycle picks the next PC from increment, branch/call target or stack top.
module program_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4,
    parameter int PC_INC      = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 stall,
    input  logic                                 branch_en,
    input  logic                                 branch_cond,
    input  logic [ADDR_W-1:0]                    branch_target,
    input  logic                                 call_en,
    input  logic                                 ret_en,
    input  logic                                 push_en,
    input  logic                                 pop_en,
    input  logic [ADDR_W-1:0]                    push_data,
    output logic [ADDR_W-1:0]                    pc,
    output logic [ADDR_W-1:0]                    stack_top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_depth,
    output logic                                 stack_full,
    output logic                                 stack_empty,
    output logic                                 redirect,
    output logic                                 stack_ovf,
    output logic                                 stack_unf
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] FULL_COUNT = DEPTH_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0]  INC        = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] entry [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] push_val;
    logic              do_push;
    logic              do_pop;
    logic              redirect_next;

    assign pc_seq      = pc + INC;
    assign stack_top   = entry[0];
    assign stack_full  = (stack_depth == FULL_COUNT);
    assign stack_empty = (stack_depth == '0);

    // Single priority chain: the first asserted command wins and the rest are ignored.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pc_next       = pc_seq;
        push_val      = push_data;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        redirect_next = 1'b0;
        if (stall) begin
            pc_next = pc;
        end else if (ret_en) begin
            pc_next       = entry[0];
            do_pop        = 1'b1;
            redirect_next = 1'b1;
        end else if (call_en) begin
            pc_next       = branch_target;
            push_val      = pc_seq;
            do_push       = 1'b1;
            redirect_next = 1'b1;
        end else if (branch_en) begin
            if (branch_cond) begin
                pc_next       = branch_target;
                redirect_next = 1'b1;
            end
        end else if (pop_en) begin
            do_pop = 1'b1;
        end else if (push_en) begin
            do_push = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            pc          <= '0;
            stack_depth <= '0;
            redirect    <= 1'b0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
            // NOTE: stack entries are cleared on reset because a pop from empty exposes them.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            pc       <= pc_next;
            redirect <= redirect_next;
            if (do_push) begin
                for (int i = STACK_DEPTH - 1; i > 0; i--) begin
                    entry[i] <= entry[i-1];
                end
                entry[0] <= push_val;
                if (stack_full) begin
                    stack_ovf <= 1'b1;
                end else begin
                    stack_depth <= stack_depth + 1'b1;
                end
            end else if (do_pop) begin
                // Bottom entry keeps its value, so repeated pops duplicate it upward.
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    entry[i] <= entry[i+1];
                end
                if (stack_empty) begin
                    stack_unf <= 1'b1;
                end else begin
                    stack_depth <= stack_depth - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus randomized
// commands compared against a queue-based behavioural model.
module tb_program_sequencer;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int MASK   = 'hFFF;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              branch_en;
    logic              branch_cond;
    logic [ADDR_W-1:0] branch_target;
    logic              call_en;
    logic              ret_en;
    logic              push_en;
    logic              pop_en;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] stack_top;
    logic [2:0]        stack_depth;
    logic              stack_full;
    logic              stack_empty;
    logic              redirect;
    logic              stack_ovf;
    logic              stack_unf;

    int total = 0;
    int bad   = 0;

    // Behavioural model: stack is a fixed-length queue, element 0 is the top.
    int m_pc;
    int m_stk[$];
    int m_depth;
    bit m_redir;
    bit m_ovf;
    bit m_unf;

    program_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .PC_INC(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
        .branch_cond(branch_cond), .branch_target(branch_target), .call_en(call_en),
        .ret_en(ret_en), .push_en(push_en), .pop_en(pop_en), .push_data(push_data),
        .pc(pc), .stack_top(stack_top), .stack_depth(stack_depth), .stack_full(stack_full),
        .stack_empty(stack_empty), .redirect(redirect), .stack_ovf(stack_ovf),
        .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        reset = 0; stall = 0; branch_en = 0; branch_cond = 0; branch_target = '0;
        call_en = 0; ret_en = 0; push_en = 0; pop_en = 0; push_data = '0;
    endtask

    task automatic m_push(input int v);
        if (m_depth == DEPTH) m_ovf = 1; else m_depth++;
        m_stk = {v, m_stk[0:DEPTH-2]};
    endtask

    task automatic m_pop();
        if (m_depth == 0) m_unf = 1; else m_depth--;
        m_stk = {m_stk[1:DEPTH-1], m_stk[DEPTH-1]};
    endtask

    task automatic model_update();
        int seq;
        seq = (m_pc + 2) & MASK;
        if (reset) begin
            m_pc = 0; m_stk = '{0, 0, 0, 0}; m_depth = 0;
            m_redir = 0; m_ovf = 0; m_unf = 0;
        end else if (stall) begin
            m_redir = 0;
        end else if (ret_en) begin
            m_pc = m_stk[0]; m_pop(); m_redir = 1;
        end else if (call_en) begin
            m_push(seq); m_pc = int'(branch_target); m_redir = 1;
        end else if (branch_en) begin
            m_pc = branch_cond ? int'(branch_target) : seq;
            m_redir = branch_cond;
        end else begin
            if (pop_en) m_pop();
            else if (push_en) m_push(int'(push_data));
            m_pc = seq; m_redir = 0;
        end
    endtask

    // One clock: inputs sampled at the edge, model follows, outputs settle by +1.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        reset = 1; tick();
    endtask

    task automatic goto_pc(input logic [ADDR_W-1:0] a);
        branch_en = 1; branch_cond = 1; branch_target = a; tick();
    endtask

    task automatic test_reset();
        int exp_pc;
        reset = 1; tick();
        reset = 1; tick();
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", pc); end
        total++; if (redirect !== 1'b0 || stack_empty !== 1'b1 || stack_depth !== 3'd0) begin
            bad++; $display("FAIL reset_flags got redir=%b empty=%b depth=%0d exp 0/1/0",
                            redirect, stack_empty, stack_depth);
        end
        total++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            bad++; $display("FAIL reset_sticky got ovf=%b unf=%b exp 0/0", stack_ovf, stack_unf);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 2 * i;
            total++; if (pc !== exp_pc[ADDR_W-1:0]) begin
                bad++; $display("FAIL idle_pc%0d got=%h exp=%h", i, pc, exp_pc[ADDR_W-1:0]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        goto_pc(12'hFFE);
        total++; if (pc !== 12'hFFE || redirect !== 1'b1) begin
            bad++; $display("FAIL wrap_setup got pc=%h redir=%b exp FFE/1", pc, redirect);
        end
        tick();
        total++; if (pc !== 12'h000 || redirect !== 1'b0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            bad++; $display("FAIL wrap got pc=%h redir=%b ovf=%b unf=%b exp 000/0/0/0",
                            pc, redirect, stack_ovf, stack_unf);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        goto_pc(12'h010);
        call_en = 1; branch_target = 12'h100; tick();
        total++; if (pc !== 12'h100 || stack_top !== 12'h012) begin
            bad++; $display("FAIL call1 got pc=%h top=%h exp 100/012", pc, stack_top);
        end
        call_en = 1; branch_target = 12'h200; tick();
        total++; if (pc !== 12'h200 || stack_top !== 12'h102 || stack_depth !== 3'd2) begin
            bad++; $display("FAIL call2 got pc=%h top=%h depth=%0d exp 200/102/2", pc, stack_top, stack_depth);
        end
        ret_en = 1; tick();
        total++; if (pc !== 12'h102 || redirect !== 1'b1) begin
            bad++; $display("FAIL ret1 got pc=%h redir=%b exp 102/1", pc, redirect);
        end
        ret_en = 1; tick();
        total++; if (pc !== 12'h012 || stack_empty !== 1'b1 || stack_unf !== 1'b0) begin
            bad++; $display("FAIL ret2 got pc=%h empty=%b unf=%b exp 012/1/0", pc, stack_empty, stack_unf);
        end
    endtask

    task automatic test_push_pop();
        logic [ADDR_W-1:0] exp_top [5];
        exp_top = '{12'h5, 12'h4, 12'h3, 12'h2, 12'h2};
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            push_en = 1; push_data = ADDR_W'(i); tick();
            total++; if (stack_ovf !== (i == 5)) begin
                bad++; $display("FAIL push%0d_ovf got=%b exp=%b", i, stack_ovf, i == 5);
            end
        end
        total++; if (stack_depth !== 3'd4 || stack_full !== 1'b1 || pc !== 12'h00A) begin
            bad++; $display("FAIL push_full got depth=%0d full=%b pc=%h exp 4/1/00A", stack_depth, stack_full, pc);
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (stack_top !== exp_top[i]) begin
                bad++; $display("FAIL pop%0d_top got=%h exp=%h", i + 1, stack_top, exp_top[i]);
            end
            pop_en = 1; tick();
            total++; if (stack_unf !== (i == 4)) begin
                bad++; $display("FAIL pop%0d_unf got=%b exp=%b", i + 1, stack_unf, i == 4);
            end
        end
        total++; if (stack_depth !== 3'd0 || stack_ovf !== 1'b1) begin
            bad++; $display("FAIL pop_end got depth=%0d ovf=%b exp 0/1", stack_depth, stack_ovf);
        end
    endtask

    task automatic test_priority();
        do_reset();
        push_en = 1; push_data = 12'h040; tick();
        call_en = 1; ret_en = 1; branch_target = 12'h500; tick();
        total++; if (pc !== 12'h040 || stack_depth !== 3'd0 || stack_top !== 12'h000 || stack_unf !== 1'b0) begin
            bad++; $display("FAIL call_ret got pc=%h depth=%0d top=%h unf=%b exp 040/0/000/0",
                            pc, stack_depth, stack_top, stack_unf);
        end
        stall = 1; call_en = 1; branch_target = 12'h500; tick();
        total++; if (pc !== 12'h040 || stack_depth !== 3'd0 || redirect !== 1'b0) begin
            bad++; $display("FAIL stall got pc=%h depth=%0d redir=%b exp 040/0/0", pc, stack_depth, redirect);
        end
        branch_en = 1; branch_cond = 1; pop_en = 1; branch_target = 12'h080; tick();
        total++; if (pc !== 12'h080 || stack_unf !== 1'b0) begin
            bad++; $display("FAIL branch_over_pop got pc=%h unf=%b exp 080/0", pc, stack_unf);
        end
        reset = 1; call_en = 1; branch_target = 12'h600; tick();
        total++; if (pc !== 12'h000 || stack_depth !== 3'd0) begin
            bad++; $display("FAIL reset_call got pc=%h depth=%0d exp 000/0", pc, stack_depth);
        end
    endtask

    task automatic test_branch();
        do_reset();
        goto_pc(12'h020);
        tick();
        total++; if (redirect !== 1'b0 || pc !== 12'h022) begin
            bad++; $display("FAIL branch_setup got pc=%h redir=%b exp 022/0", pc, redirect);
        end
        goto_pc(12'h020);
        branch_en = 1; branch_cond = 0; branch_target = 12'h300; tick();
        total++; if (pc !== 12'h022 || redirect !== 1'b0) begin
            bad++; $display("FAIL branch_nt got pc=%h redir=%b exp 022/0", pc, redirect);
        end
        branch_en = 1; branch_cond = 1; branch_target = 12'h300; tick();
        total++; if (pc !== 12'h300 || redirect !== 1'b1) begin
            bad++; $display("FAIL branch_t got pc=%h redir=%b exp 300/1", pc, redirect);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 99) < 2);
            stall         = ($urandom_range(0, 99) < 10);
            ret_en        = ($urandom_range(0, 99) < 12);
            call_en       = ($urandom_range(0, 99) < 12);
            branch_en     = ($urandom_range(0, 99) < 15);
            branch_cond   = $urandom_range(0, 1) == 1;
            pop_en        = ($urandom_range(0, 99) < 15);
            push_en       = ($urandom_range(0, 99) < 20);
            branch_target = ADDR_W'($urandom);
            push_data     = ADDR_W'($urandom);
            tick();
            total++; if (pc !== m_pc[ADDR_W-1:0] || stack_top !== m_stk[0][ADDR_W-1:0]) begin
                bad++; $display("FAIL rnd%0d_pc_top got pc=%h top=%h exp %h/%h",
                                n, pc, stack_top, m_pc[ADDR_W-1:0], m_stk[0][ADDR_W-1:0]);
            end
            total++; if (stack_depth !== m_depth[2:0] || stack_full !== (m_depth == DEPTH)
                         || stack_empty !== (m_depth == 0)) begin
                bad++; $display("FAIL rnd%0d_depth got depth=%0d full=%b empty=%b exp depth=%0d",
                                n, stack_depth, stack_full, stack_empty, m_depth);
            end
            total++; if (redirect !== m_redir || stack_ovf !== m_ovf || stack_unf !== m_unf) begin
                bad++; $display("FAIL rnd%0d_flags got redir=%b ovf=%b unf=%b exp %b/%b/%b",
                                n, redirect, stack_ovf, stack_unf, m_redir, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        m_pc = 0; m_stk = '{0, 0, 0, 0}; m_depth = 0; m_redir = 0; m_ovf = 0; m_unf = 0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_wrap();
        test_call_ret();
        test_push_pop();
        test_priority();
        test_branch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
